// File: rtl/arbitro_memoria.sv
// ---------------------------------------------------------------------------
// arbitro_memoria
//
// Arbitrates a single shared memory between an instruction-fetch port and a
// data port. Only one memory transaction is in flight at any time. Each
// transaction runs IDLE -> WAIT -> RESP. The winner's ready output pulses for
// one cycle, LATENCY+2 cycles after the request is accepted.
//
// Parameters
//   LATENCY      memory cycles from the ram_en pulse to valid ram_rdata (1..15)
//   GUARD_LIMIT  consecutive data grants tolerated while fetch waits (1..15)
//
// Optional feature (compile-time macro)
//   ARB_STARVATION_GUARD_EN  defined   : fetch preempts data after GUARD_LIMIT
//                                        consecutive data grants while fetch waits
//                            undefined : strict data-port priority
//
// Ports
//   clock, reset          rising-edge clock, asynchronous active-high reset
//   if_req/if_addr        fetch request (held until if_ready) and PC
//   if_rdata/if_ready     fetched instruction and one-cycle completion pulse
//   dm_req/dm_we          data request (held until dm_ready), write qualifier
//   dm_addr/dm_wdata      data address and store data
//   dm_rdata/dm_ready     load data and one-cycle completion pulse
//   ram_en/ram_we         one-cycle access strobe and write qualifier
//   ram_addr/ram_wdata    address/data, held from ram_en until the response
//   ram_rdata             memory read data, valid LATENCY cycles after ram_en
// ---------------------------------------------------------------------------
module arbitro_memoria #(
    parameter int LATENCY     = 2,
    parameter int GUARD_LIMIT = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ready,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic [31:0] dm_rdata,
    output logic        dm_ready,
    output logic        ram_en,
    output logic        ram_we,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      r_state;
    logic [3:0]  r_waitCnt;
    logic        r_isFetch;
    logic        r_isWrite;
    logic        r_ramEn;
    logic        r_ramWe;
    logic [31:0] r_ramAddr;
    logic [31:0] r_ramWdata;
    logic [31:0] r_ifRdata;
    logic [31:0] r_dmRdata;
    logic        r_ifReady;
    logic        r_dmReady;

    logic w_anyReq;
    logic w_fetchWins;
    logic w_guardTrip;

    assign w_anyReq = if_req | dm_req;

    // Data normally wins so the pipeline can drain; fetch only wins when it is
    // alone or when the starvation guard has tripped.
    assign w_fetchWins = if_req & (~dm_req | w_guardTrip);

`ifdef ARB_STARVATION_GUARD_EN
    logic [3:0] r_guardCnt;

    assign w_guardTrip = if_req & (r_guardCnt == 4'(GUARD_LIMIT));

    // Counts data grants that overtook a waiting fetch. Any grant without a
    // waiting fetch, or a fetch grant, starts the count over. The trip forces
    // a fetch grant, so the count never exceeds GUARD_LIMIT.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_guardCnt <= 4'd0;
        end else if (r_state == IDLE && w_anyReq) begin
            if (w_fetchWins || !if_req) begin
                r_guardCnt <= 4'd0;
            end else begin
                r_guardCnt <= r_guardCnt + 4'd1;
            end
        end
    end
`else
    // Without the guard, fetch never preempts data. GUARD_LIMIT is legal only
    // in 1..15, so this term is always zero; it keeps both builds sharing one
    // parameter list.
    assign w_guardTrip = 1'b0 & (GUARD_LIMIT == 0);
`endif

    // Transaction FSM. Every output is a register. Strobes default low each
    // cycle so ram_en and the ready pulses last exactly one cycle. The
    // address and write data stay put until the next grant.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_waitCnt  <= 4'd0;
            r_isFetch  <= 1'b0;
            r_isWrite  <= 1'b0;
            r_ramEn    <= 1'b0;
            r_ramWe    <= 1'b0;
            r_ramAddr  <= 32'd0;
            r_ramWdata <= 32'd0;
            r_ifRdata  <= 32'd0;
            r_dmRdata  <= 32'd0;
            r_ifReady  <= 1'b0;
            r_dmReady  <= 1'b0;
        end else begin
            r_ramEn   <= 1'b0;
            r_ramWe   <= 1'b0;
            r_ifReady <= 1'b0;
            r_dmReady <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_anyReq) begin
                        r_isFetch  <= w_fetchWins;
                        r_isWrite  <= ~w_fetchWins & dm_we;
                        r_ramEn    <= 1'b1;
                        r_ramWe    <= ~w_fetchWins & dm_we;
                        r_ramAddr  <= w_fetchWins ? if_addr : dm_addr;
                        r_ramWdata <= (~w_fetchWins & dm_we) ? dm_wdata : 32'd0;
                        r_waitCnt  <= 4'(LATENCY);
                        r_state    <= WAIT;
                    end
                end
                WAIT: begin
                    // The count holds LATENCY during the ram_en cycle, so it
                    // reaches zero exactly when ram_rdata becomes valid.
                    if (r_waitCnt == 4'd0) begin
                        if (r_isFetch) begin
                            r_ifRdata <= ram_rdata;
                            r_ifReady <= 1'b1;
                        end else begin
                            if (!r_isWrite) begin
                                r_dmRdata <= ram_rdata;
                            end
                            r_dmReady <= 1'b1;
                        end
                        r_state <= RESP;
                    end else begin
                        r_waitCnt <= r_waitCnt - 4'd1;
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign if_rdata  = r_ifRdata;
    assign if_ready  = r_ifReady;
    assign dm_rdata  = r_dmRdata;
    assign dm_ready  = r_dmReady;
    assign ram_en    = r_ramEn;
    assign ram_we    = r_ramWe;
    assign ram_addr  = r_ramAddr;
    assign ram_wdata = r_ramWdata;

endmodule

// File: tb/tb_arbitro_memoria.sv
// ---------------------------------------------------------------------------
// tb_arbitro_memoria
//
// Scoreboard bench for arbitro_memoria. Each request round pushes the
// expected completions into a queue. The queue holds port, data and the cycle
// of the ready pulse, all derived from the arbitration rules and a reference
// memory. A monitor pops and compares on every ready pulse. A memory
// responder returns data exactly LATENCY cycles after ram_en and random junk
// at all other times. Two extra instances (LATENCY=1 and LATENCY=15) check
// back-to-back spacing. Define ARB_STARVATION_GUARD_EN to match a guard build.
// ---------------------------------------------------------------------------
module tb_arbitro_memoria;

    localparam int LAT  = 2;
    localparam int GLIM = 4;

    logic        clock;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_ready;
    logic        ram_en;
    logic        ram_we;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    // Signals for the latency-sweep instances.
    logic        xReq1, xReady1, xEn1, xWe1, xDmReady1;
    logic [31:0] xRdata1, xDmRdata1, xAddr1, xWdata1;
    logic        xReq15, xReady15, xEn15, xWe15, xDmReady15;
    logic [31:0] xRdata15, xDmRdata15, xAddr15, xWdata15;
    logic [31:0] xRam1, xRam15, zero32;
    logic        zero1;

    typedef struct {
        bit          isFetch;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t        expQ[$];
    logic [31:0] refMem[logic [31:0]];
    logic [31:0] ramMem[logic [31:0]];
    logic [31:0] lastDmRead;
    int          checks;
    int          errors;
    int          cyc;

    arbitro_memoria #(.LATENCY(LAT), .GUARD_LIMIT(GLIM)) dut (
        .clock(clock), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_ready(dm_ready),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    arbitro_memoria #(.LATENCY(1), .GUARD_LIMIT(GLIM)) u1 (
        .clock(clock), .reset(reset),
        .if_req(xReq1), .if_addr(zero32), .if_rdata(xRdata1), .if_ready(xReady1),
        .dm_req(zero1), .dm_we(zero1), .dm_addr(zero32), .dm_wdata(zero32),
        .dm_rdata(xDmRdata1), .dm_ready(xDmReady1),
        .ram_en(xEn1), .ram_we(xWe1), .ram_addr(xAddr1), .ram_wdata(xWdata1),
        .ram_rdata(xRam1)
    );

    arbitro_memoria #(.LATENCY(15), .GUARD_LIMIT(GLIM)) u15 (
        .clock(clock), .reset(reset),
        .if_req(xReq15), .if_addr(zero32), .if_rdata(xRdata15), .if_ready(xReady15),
        .dm_req(zero1), .dm_we(zero1), .dm_addr(zero32), .dm_wdata(zero32),
        .dm_rdata(xDmRdata15), .dm_ready(xDmReady15),
        .ram_en(xEn15), .ram_we(xWe15), .ram_addr(xAddr15), .ram_wdata(xWdata15),
        .ram_rdata(xRam15)
    );

    function automatic logic [31:0] initVal(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h13579BDF;
    endfunction

    function automatic logic [31:0] refRead(input logic [31:0] a);
        return refMem.exists(a) ? refMem[a] : initVal(a);
    endfunction

    function automatic logic [31:0] ramRead(input logic [31:0] a);
        return ramMem.exists(a) ? ramMem[a] : initVal(a);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic failNow(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s (cycle %0d)", name, cyc);
    endtask

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clock);
            cyc++;
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    // Memory responder: the data is valid only in the cycle LATENCY after
    // ram_en. Writes land in the responder's memory when the strobe is seen.
    initial begin
        int          pend;
        logic [31:0] pAddr;
        logic        fire;
        pend      = 0;
        pAddr     = 32'd0;
        ram_rdata = 32'd0;
        forever begin
            @(negedge clock);
            fire = 1'b0;
            if (pend > 0) begin
                pend--;
                fire = (pend == 0);
            end
            ram_rdata = fire ? ramRead(pAddr) : $urandom();
            if (reset) begin
                pend = 0;
            end else if (ram_en) begin
                pAddr = ram_addr;
                pend  = LAT;
                if (ram_we) ramMem[ram_addr] = ram_wdata;
            end
        end
    end

    // Monitor: every ready pulse must match the oldest expected completion.
    initial begin
        exp_t e;
        logic prevEn;
        prevEn = 1'b0;
        forever begin
            @(negedge clock);
            if (reset) begin
                prevEn = 1'b0;
            end else begin
                if (ram_en) checkOutput("ramEnGap", {31'd0, prevEn}, 32'd0);
                prevEn = ram_en;
                if (if_ready && dm_ready) failNow("bothReady");
                if (if_ready || dm_ready) begin
                    if (expQ.size() == 0) begin
                        failNow(if_ready ? "unexpectedIfReady" : "unexpectedDmReady");
                    end else begin
                        e = expQ.pop_front();
                        checkOutput("readyPort", {31'd0, if_ready}, {31'd0, e.isFetch});
                        checkOutput("readyCycle", 32'(cyc), 32'(e.cyc));
                        if (if_ready) checkOutput("ifRdata", if_rdata, e.data);
                        else          checkOutput("dmRdata", dm_rdata, e.data);
                    end
                end
            end
        end
    end

    // kind: 0 fetch only, 1 data only, 2 both together.
    task automatic applyStimulus(input int kind, input logic [31:0] fAddr, input bit dWe,
                                 input logic [31:0] dAddr, input logic [31:0] dWdata,
                                 input bit dropEarly);
        int n;
        bit wantIf, wantDm;
        exp_t e;
        @(posedge clock);
        #1;
        n      = cyc;
        wantDm = (kind != 0);
        wantIf = (kind != 1);
        if (wantDm) begin
            if (dWe) refMem[dAddr] = dWdata;
            else     lastDmRead = refRead(dAddr);
            e.isFetch = 1'b0;
            e.data    = lastDmRead;
            e.cyc     = n + LAT + 2;
            expQ.push_back(e);
        end
        if (wantIf) begin
            e.isFetch = 1'b1;
            e.data    = refRead(fAddr);
            e.cyc     = wantDm ? n + 2 * LAT + 5 : n + LAT + 2;
            expQ.push_back(e);
        end
        if_req   = wantIf;
        if_addr  = fAddr;
        dm_req   = wantDm;
        dm_we    = dWe;
        dm_addr  = dAddr;
        dm_wdata = dWdata;
        if (dropEarly && kind != 2) begin
            @(posedge clock);
            #1;
            if_req = 1'b0;
            dm_req = 1'b0;
        end
        for (int k = 0; k < 4 * LAT + 20 && (wantIf || wantDm); k++) begin
            @(negedge clock);
            if (dm_ready && wantDm) begin
                wantDm = 1'b0;
                dm_req = 1'b0;
            end
            if (if_ready && wantIf) begin
                wantIf = 1'b0;
                if_req = 1'b0;
            end
        end
        if (wantIf || wantDm) begin
            failNow("roundTimeout");
            if_req = 1'b0;
            dm_req = 1'b0;
        end
    endtask

    task automatic sweepStep(input string tag, input logic rdy, input logic en,
                             input logic [31:0] rd, input logic [31:0] expRd, input int lat,
                             input int n, inout int last, inout int cnt, inout logic prevEn);
        if (en) checkOutput({tag, "EnGap"}, {31'd0, prevEn}, 32'd0);
        prevEn = en;
        if (rdy) begin
            if (last < 0) checkOutput({tag, "FirstReady"}, 32'(cyc), 32'(n + lat + 2));
            else          checkOutput({tag, "Spacing"}, 32'(cyc - last), 32'(lat + 3));
            checkOutput({tag, "Rdata"}, rd, expRd);
            last = cyc;
            cnt++;
        end
    endtask

    initial begin
        int          n, last1, last15, cnt1, cnt15, seen, nData;
        logic        pe1, pe15;
        bit          done;
        exp_t        e;
        logic [31:0] a;

        checks = 0; errors = 0; lastDmRead = 32'd0;
        reset = 1'b0; if_req = 1'b0; if_addr = 32'd0; dm_req = 1'b0; dm_we = 1'b0;
        dm_addr = 32'd0; dm_wdata = 32'd0; xReq1 = 1'b0; xReq15 = 1'b0;
        zero32 = 32'd0; zero1 = 1'b0; xRam1 = 32'h11111111; xRam15 = 32'hF0F0F0F0;
        refMem[32'h40] = 32'h8C220004;
        ramMem[32'h40] = 32'h8C220004;

        #2 reset = 1'b1;
        #1;
        checkOutput("rstIfRdata", if_rdata, 32'd0);
        checkOutput("rstDmRdata", dm_rdata, 32'd0);
        checkOutput("rstStrobes", {28'd0, if_ready, dm_ready, ram_en, ram_we}, 32'd0);
        checkOutput("rstRamAddr", ram_addr, 32'd0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;

        $display("[TB] directed transactions");
        applyStimulus(0, 32'h40, 1'b0, 32'd0, 32'd0, 1'b0);
        applyStimulus(1, 32'd0, 1'b1, 32'h100, 32'hDEADBEEF, 1'b0);
        applyStimulus(1, 32'd0, 1'b0, 32'h100, 32'd0, 1'b0);
        applyStimulus(2, 32'h40, 1'b0, 32'h100, 32'd0, 1'b0);
        applyStimulus(2, 32'h100, 1'b1, 32'h100, 32'hCAFEF00D, 1'b0);

        $display("[TB] randomized transactions");
        for (int r = 0; r < 60; r++) begin
            a = 32'h200 + 32'($urandom_range(0, 7)) * 32'd4;
            applyStimulus($urandom_range(0, 2), 32'h200 + 32'($urandom_range(0, 7)) * 32'd4,
                          1'($urandom_range(0, 1)), a, $urandom(), ($urandom_range(0, 3) == 0));
            repeat ($urandom_range(0, 2)) @(posedge clock);
        end

        $display("[TB] latency sweep");
        @(posedge clock);
        #1;
        n = cyc; xReq1 = 1'b1; xReq15 = 1'b1;
        last1 = -1; last15 = -1; cnt1 = 0; cnt15 = 0; pe1 = 1'b0; pe15 = 1'b0;
        for (int k = 0; k < 6 * 18 + 20 && (cnt1 < 5 || cnt15 < 5); k++) begin
            @(negedge clock);
            sweepStep("lat1", xReady1, xEn1, xRdata1, 32'h11111111, 1, n, last1, cnt1, pe1);
            sweepStep("lat15", xReady15, xEn15, xRdata15, 32'hF0F0F0F0, 15, n, last15, cnt15, pe15);
        end
        if (cnt1 < 5 || cnt15 < 5) failNow("sweepTimeout");
        xReq1 = 1'b0; xReq15 = 1'b0;
        repeat (40) @(posedge clock);

        $display("[TB] reset during fetch wait");
        @(posedge clock);
        #1;
        if_req = 1'b1; if_addr = 32'h44;
        @(posedge clock);
        @(posedge clock);
        #3 reset = 1'b1;
        #1;
        checkOutput("midRstIfRdata", if_rdata, 32'd0);
        checkOutput("midRstDmRdata", dm_rdata, 32'd0);
        checkOutput("midRstRamAddr", ram_addr, 32'd0);
        checkOutput("midRstRamWdata", ram_wdata, 32'd0);
        checkOutput("midRstStrobes", {28'd0, if_ready, dm_ready, ram_en, ram_we}, 32'd0);
        if_req = 1'b0;
        lastDmRead = 32'd0;
        @(posedge clock);
        #1 reset = 1'b0;
        repeat (20) @(posedge clock);

        $display("[TB] both ports held continuously");
`ifdef ARB_STARVATION_GUARD_EN
        nData = GLIM;
`else
        nData = 6;
`endif
        @(posedge clock);
        #1;
        n = cyc;
        lastDmRead = refRead(32'h20);
        for (int k = 0; k < nData; k++) begin
            e.isFetch = 1'b0;
            e.data    = lastDmRead;
            e.cyc     = n + k * (LAT + 3) + LAT + 2;
            expQ.push_back(e);
        end
        e.isFetch = 1'b1;
        e.data    = refRead(32'h40);
        e.cyc     = n + nData * (LAT + 3) + LAT + 2;
        expQ.push_back(e);
        if_req = 1'b1; if_addr = 32'h40; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h20;
        seen = 0; done = 1'b0;
        for (int k = 0; k < (nData + 2) * (LAT + 3) + 20 && !done; k++) begin
            @(negedge clock);
            if (dm_ready) begin
                seen++;
`ifndef ARB_STARVATION_GUARD_EN
                if (seen == nData) dm_req = 1'b0;
`endif
            end
            if (if_ready) begin
                if_req = 1'b0;
                dm_req = 1'b0;
                done   = 1'b1;
            end
        end
        if (!done) begin
            failNow("heldTimeout");
            if_req = 1'b0;
            dm_req = 1'b0;
        end

        repeat (30) @(posedge clock);
        checkOutput("queueDrained", 32'(expQ.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
